// File: rtl/vending_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vending_pkg                                                          |
// | 7-segment codes, converter state type and BCD sizing helper.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vending_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } conv_state_t;

  // Segment order {A,B,C,D,E,F,G}, bit 6 = A
  localparam logic [6:0] c_seg_0     = 7'b1111110;
  localparam logic [6:0] c_seg_1     = 7'b0110000;
  localparam logic [6:0] c_seg_2     = 7'b1101101;
  localparam logic [6:0] c_seg_3     = 7'b1111001;
  localparam logic [6:0] c_seg_4     = 7'b0110011;
  localparam logic [6:0] c_seg_5     = 7'b1011011;
  localparam logic [6:0] c_seg_6     = 7'b1011111;
  localparam logic [6:0] c_seg_7     = 7'b1110000;
  localparam logic [6:0] c_seg_8     = 7'b1111111;
  localparam logic [6:0] c_seg_9     = 7'b1111011;
  localparam logic [6:0] c_seg_dash  = 7'b0000001;
  localparam logic [6:0] c_seg_blank = 7'b0000000;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return c_seg_0;
      4'd1:    return c_seg_1;
      4'd2:    return c_seg_2;
      4'd3:    return c_seg_3;
      4'd4:    return c_seg_4;
      4'd5:    return c_seg_5;
      4'd6:    return c_seg_6;
      4'd7:    return c_seg_7;
      4'd8:    return c_seg_8;
      4'd9:    return c_seg_9;
      default: return c_seg_blank;
    endcase
  endfunction

  // ceil(width * log10(2)) using a fixed-point approximation of log10(2)
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debounce                                                         |
// | One key channel: tick-sampled integrator with rising-edge strobe.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module key_debounce
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic FPGA_CLK,
  input  logic FPGA_RSTB,
  input  logic i_tick,
  input  logic i_sample,
  output logic o_level,
  output logic o_pulse
);

  logic [3:0] r_cnt;
  logic       r_level;
  logic       r_pulse;

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (i_tick) begin
        if (i_sample != r_level) begin
          if (r_cnt == 4'(DEBOUNCE_TICKS - 1)) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
            // Strobe only when the level is about to become 1
            r_pulse <= ~r_level;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/vending_panel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vending_panel                                                        |
// | Debounced key inputs plus scanned decimal 7-segment display.        |
// | Define VENDING_PANEL_ZBLANK_EN to blank leading zero digits.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vending_panel
  import vending_pkg::*;
#(
  parameter int TICK_DIV       = 500000,
  parameter int N_KEYS         = 5,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int N_DIGITS       = 6,
  parameter int VAL_W          = 16,
  parameter int SCAN_DIV       = 50000
) (
  input  logic                FPGA_CLK,
  input  logic                FPGA_RSTB,
  input  logic [N_KEYS-1:0]   DIP_SW,
  input  logic [VAL_W-1:0]    VALUE,
  output logic [N_KEYS-1:0]   KEY_LEVEL,
  output logic [N_KEYS-1:0]   KEY_PULSE,
  output logic [N_DIGITS-1:0] DIGIT,
  output logic [6:0]          SEG,
  output logic                SEG_DP,
  output logic                OVERFLOW
);

  localparam int NB     = bcd_digits(VAL_W);
  localparam int NBD    = (NB > N_DIGITS) ? NB : N_DIGITS;
  localparam int BCD_W  = 4 * NBD;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SH_W   = $clog2(VAL_W);

  // Key path: the idle-high switch level is the reset value so release is quiet
  logic [N_KEYS-1:0] r_sync1, r_sync2;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_tick_cnt <= '0;
    end else begin
      r_sync1    <= DIP_SW;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key (
      .FPGA_CLK  (FPGA_CLK),
      .FPGA_RSTB (FPGA_RSTB),
      .i_tick    (w_tick),
      .i_sample  (~r_sync2[k]),
      .o_level   (KEY_LEVEL[k]),
      .o_pulse   (KEY_PULSE[k])
    );
  end

  // Double-dabble converter
  conv_state_t       r_state;
  logic [VAL_W-1:0]  r_bin;
  logic [4*NB-1:0]   r_work, w_adj;
  logic [SH_W-1:0]   r_sh_cnt;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_overflow, w_overflow;

  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < NB; d++)
      if (r_work[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
  end

  always_comb begin
    w_overflow = 1'b0;
    for (int d = N_DIGITS; d < NB; d++)
      if (r_work[4*d +: 4] != 4'd0) w_overflow = 1'b1;
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_work     <= '0;
      r_sh_cnt   <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_LOAD;
        S_LOAD: begin
          r_bin    <= VALUE;
          r_work   <= '0;
          r_sh_cnt <= '0;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          r_work   <= {w_adj[4*NB-2:0], r_bin[VAL_W-1]};
          r_bin    <= r_bin << 1;
          r_sh_cnt <= r_sh_cnt + 1'b1;
          if (r_sh_cnt == SH_W'(VAL_W - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd      <= BCD_W'(r_work);
          r_overflow <= w_overflow;
          r_state    <= S_LOAD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Display scan
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [IDX_W-1:0]    r_idx, w_idx_next;
  logic                w_adv;
  logic [N_DIGITS-1:0] r_digit;
  logic [6:0]          r_seg, w_seg_next;
  logic [3:0]          w_dig [N_DIGITS];
  logic [N_DIGITS-1:0] w_blank;

  assign w_adv = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    w_idx_next = r_idx;
    if (w_adv) w_idx_next = (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
  end

  always_comb begin
    for (int p = 0; p < N_DIGITS; p++) w_dig[p] = r_bcd[4*p +: 4];
  end

`ifdef VENDING_PANEL_ZBLANK_EN
  logic w_zero_run;
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int p = N_DIGITS - 1; p >= 1; p--) begin
      w_zero_run = w_zero_run && (w_dig[p] == 4'd0);
      w_blank[p] = w_zero_run;
    end
  end
`else
  assign w_blank = '0;
`endif

  always_comb begin
    if (r_overflow)                w_seg_next = c_seg_dash;
    else if (w_blank[w_idx_next])  w_seg_next = c_seg_blank;
    else                           w_seg_next = seg_decode(w_dig[w_idx_next]);
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
    if (!FPGA_RSTB) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_digit    <= ~N_DIGITS'(1);
      r_seg      <= c_seg_0;
    end else begin
      r_scan_cnt <= w_adv ? '0 : r_scan_cnt + 1'b1;
      r_idx      <= w_idx_next;
      r_digit    <= ~(N_DIGITS'(1) << w_idx_next);
      r_seg      <= w_seg_next;
    end
  end

  assign DIGIT    = r_digit;
  assign SEG      = r_seg;
  assign SEG_DP   = 1'b0;
  assign OVERFLOW = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vending_panel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vending_panel                                                     |
// | Directed bench: debounce, conversion, scan, overflow, reset.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vending_panel;

  localparam int N_KEYS   = 5;
  localparam int N_DIGITS = 4;
  localparam int VAL_W    = 16;

  logic                FPGA_CLK = 1'b0;
  logic                FPGA_RSTB;
  logic [N_KEYS-1:0]   DIP_SW;
  logic [VAL_W-1:0]    VALUE;
  logic [N_KEYS-1:0]   KEY_LEVEL;
  logic [N_KEYS-1:0]   KEY_PULSE;
  logic [N_DIGITS-1:0] DIGIT;
  logic [6:0]          SEG;
  logic                SEG_DP;
  logic                OVERFLOW;

  int n_vec = 0;
  int n_err = 0;
  int pcount [N_KEYS];
  int pfirst [N_KEYS];
  logic [N_KEYS-1:0] lvl_seen;
  logic [6:0] seg_tab [10];
  logic [6:0] seg_dash;
  logic [6:0] seg_blank;

  always #5 FPGA_CLK = ~FPGA_CLK;

  vending_panel #(
    .TICK_DIV       (4),
    .N_KEYS         (N_KEYS),
    .DEBOUNCE_TICKS (3),
    .N_DIGITS       (N_DIGITS),
    .VAL_W          (VAL_W),
    .SCAN_DIV       (8)
  ) dut (
    .FPGA_CLK  (FPGA_CLK),
    .FPGA_RSTB (FPGA_RSTB),
    .DIP_SW    (DIP_SW),
    .VALUE     (VALUE),
    .KEY_LEVEL (KEY_LEVEL),
    .KEY_PULSE (KEY_PULSE),
    .DIGIT     (DIGIT),
    .SEG       (SEG),
    .SEG_DP    (SEG_DP),
    .OVERFLOW  (OVERFLOW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < N_KEYS; k++) begin
      pcount[k] = 0;
      pfirst[k] = -1;
    end
    lvl_seen = '0;
  endtask

  task automatic run_mon(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge FPGA_CLK);
      for (int k = 0; k < N_KEYS; k++) begin
        if (KEY_PULSE[k] === 1'b1) begin
          pcount[k]++;
          if (pfirst[k] < 0) pfirst[k] = c;
        end
      end
      lvl_seen = lvl_seen | KEY_LEVEL;
    end
  endtask

  // Walk digits 0..3, checking SEG while each digit is selected
  task automatic check_scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg [4];
    logic [3:0] one;
    exp_seg = '{e0, e1, e2, e3};
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] want;
      int t;
      want = ~(one << k);
      t = 0;
      while (DIGIT !== want && t < 64) begin
        @(negedge FPGA_CLK);
        t++;
      end
      chk($sformatf("%s_sel%0d", tag, k), 32'(DIGIT), 32'(want));
      chk($sformatf("%s_seg%0d", tag, k), 32'(SEG), 32'(exp_seg[k]));
    end
  endtask

  initial begin
    int span;
    logic seen_off;

    seg_tab   = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    seg_dash  = 7'b0000001;
    seg_blank = 7'b0000000;

    FPGA_RSTB = 1'b0;
    DIP_SW    = '1;
    VALUE     = '0;
    repeat (3) @(negedge FPGA_CLK);
    chk("rst_level",    32'(KEY_LEVEL), 32'h0);
    chk("rst_pulse",    32'(KEY_PULSE), 32'h0);
    chk("rst_overflow", 32'(OVERFLOW),  32'h0);
    chk("rst_digit",    32'(DIGIT),     32'hE);
    chk("rst_seg",      32'(SEG),       32'(seg_tab[0]));
    chk("rst_dp",       32'(SEG_DP),    32'h0);

    // First conversion after release: LOAD, 16 shifts, DONE, then SEG register
    VALUE = 16'd1234;
    FPGA_RSTB = 1'b1;
    repeat (20) @(negedge FPGA_CLK);
    chk("lat_digit", 32'(DIGIT), 32'hB);
    chk("lat_seg",   32'(SEG),   32'(seg_tab[2]));
    check_scan("v1234", seg_tab[4], seg_tab[3], seg_tab[2], seg_tab[1]);

    // Scan period: digit 0 is reselected every 4 * 8 cycles
    seen_off = 1'b0;
    while (DIGIT === 4'hE) @(negedge FPGA_CLK);
    while (DIGIT !== 4'hE) @(negedge FPGA_CLK);
    span = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge FPGA_CLK);
      span = n;
      if (DIGIT !== 4'hE) seen_off = 1'b1;
      else if (seen_off) break;
    end
    chk("scan_wrap", 32'(span), 32'd32);

    // Clean press and release of key 0
    DIP_SW[0] = 1'b0;
    clear_mon();
    run_mon(40);
    chk("k0_level_on",  32'(KEY_LEVEL[0]), 32'h1);
    chk("k0_pulses_on", 32'(pcount[0]),    32'd1);
    DIP_SW[0] = 1'b1;
    clear_mon();
    run_mon(40);
    chk("k0_level_off",  32'(KEY_LEVEL[0]), 32'h0);
    chk("k0_pulses_off", 32'(pcount[0]),    32'd0);

    // Glitch on key 1 lasting two ticks
    DIP_SW[1] = 1'b0;
    clear_mon();
    run_mon(8);
    DIP_SW[1] = 1'b1;
    run_mon(40);
    chk("k1_level_seen", 32'(lvl_seen[1]), 32'h0);
    chk("k1_pulses",     32'(pcount[1]),   32'd0);

    // Keys 2 and 3 pressed together
    DIP_SW[3:2] = 2'b00;
    clear_mon();
    run_mon(40);
    chk("k2_pulses", 32'(pcount[2]), 32'd1);
    chk("k3_pulses", 32'(pcount[3]), 32'd1);
    chk("k23_same_cycle", 32'(pfirst[3]), 32'(pfirst[2]));
    chk("k23_levels", 32'(KEY_LEVEL[3:2]), 32'h3);
    DIP_SW[3:2] = 2'b11;
    run_mon(40);

    // Overflow boundary
    VALUE = 16'd10000;
    repeat (40) @(negedge FPGA_CLK);
    chk("ovf_10000", 32'(OVERFLOW), 32'h1);
    check_scan("v10000", seg_dash, seg_dash, seg_dash, seg_dash);
    VALUE = 16'd9999;
    repeat (40) @(negedge FPGA_CLK);
    chk("ovf_9999", 32'(OVERFLOW), 32'h0);
    check_scan("v9999", seg_tab[9], seg_tab[9], seg_tab[9], seg_tab[9]);

    VALUE = 16'd7;
    repeat (40) @(negedge FPGA_CLK);
`ifdef VENDING_PANEL_ZBLANK_EN
    check_scan("v7", seg_tab[7], seg_blank, seg_blank, seg_blank);
`else
    check_scan("v7", seg_tab[7], seg_tab[0], seg_tab[0], seg_tab[0]);
`endif

    // Reset mid-conversion and mid-debounce
    VALUE = 16'd10000;
    repeat (40) @(negedge FPGA_CLK);
    chk("pre_rst_ovf", 32'(OVERFLOW), 32'h1);
    VALUE = 16'd1234;
    repeat (5) @(negedge FPGA_CLK);
    DIP_SW[4] = 1'b0;
    repeat (8) @(negedge FPGA_CLK);
    chk("pre_rst_k4", 32'(KEY_LEVEL[4]), 32'h0);
    #2 FPGA_RSTB = 1'b0;
    #1;
    chk("mid_rst_level",    32'(KEY_LEVEL), 32'h0);
    chk("mid_rst_pulse",    32'(KEY_PULSE), 32'h0);
    chk("mid_rst_overflow", 32'(OVERFLOW),  32'h0);
    chk("mid_rst_digit",    32'(DIGIT),     32'hE);
    chk("mid_rst_seg",      32'(SEG),       32'(seg_tab[0]));
    chk("mid_rst_dp",       32'(SEG_DP),    32'h0);
    DIP_SW = '1;
    repeat (3) @(negedge FPGA_CLK);
    FPGA_RSTB = 1'b1;
    clear_mon();
    run_mon(40);
    chk("post_rst_pulses", 32'(pcount[0] + pcount[1] + pcount[2] + pcount[3] + pcount[4]), 32'd0);
    chk("post_rst_levels", 32'(lvl_seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vending_panel.md
VENDING_PANEL -- requirements
Module: vending_panel

Interface
REQ-001 Parameter TICK_DIV, default 500000: FPGA_CLK cycles per debounce sample tick (≥2).
REQ-002 Parameter N_KEYS, default 5: number of key channels (1..16).
REQ-003 Parameter DEBOUNCE_TICKS, default 3: consecutive equal tick samples needed to change a key level (1..15).
REQ-004 Parameter N_DIGITS, default 6: number of 7-segment digits (1..8).
REQ-005 Parameter VAL_W, default 16: width of the displayed binary value (4..27).
REQ-006 Parameter SCAN_DIV, default 50000: FPGA_CLK cycles per digit in the display scan (≥2).
REQ-007 The reset is FPGA_RSTB (asynchronous, active-low) and the clock is FPGA_CLK.
REQ-008 FPGA_CLK  in  1  system clock.
REQ-009 FPGA_RSTB  in  1  asynchronous active-low reset.
REQ-010 DIP_SW  in  N_KEYS  raw, asynchronous, active-low switches.
REQ-011 VALUE  in  VAL_W  unsigned binary value to display in decimal.
REQ-012 KEY_LEVEL  out  N_KEYS  debounced key state, active-high.
REQ-013 KEY_PULSE  out  N_KEYS  single-cycle strobe on each debounced 0->1 transition.
REQ-014 DIGIT  out  N_DIGITS  one-hot digit select, active-low.
REQ-015 SEG  out  7  segments {A,B,C,D,E,F,G} (bit 6 = A), active-high.
REQ-016 SEG_DP  out  1  decimal point, active-high.
REQ-017 OVERFLOW  out  1  high while the latched value exceeds 10^N_DIGITS-1.

Function
REQ-018 Each DIP_SW bit SHALL pass through a 2-flop synchroniser and be inverted.
REQ-019 A free-running counter SHALL assert a tick enable for one cycle every TICK_DIV cycles; no derived clocks.
REQ-020 On each tick, per channel: if the sample differs from KEY_LEVEL, increment that channel's counter; otherwise clear it.
REQ-021 When a channel's counter reaches DEBOUNCE_TICKS, KEY_LEVEL SHALL toggle and the counter SHALL clear.
REQ-022 KEY_PULSE[i] SHALL be high for exactly one FPGA_CLK cycle, in the first cycle KEY_LEVEL[i] reads 1; falling transitions produce no pulse.
REQ-023 Channels SHALL be independent; simultaneous transitions on several keys SHALL each produce their own pulse in the same cycle.
REQ-024 The converter SHALL be a sequential double-dabble FSM with states IDLE -> LOAD (capture VALUE) -> SHIFT (VAL_W cycles) -> DONE -> LOAD, running continuously.
REQ-025 In DONE, the BCD digits and OVERFLOW SHALL update together in one cycle, so the display never shows a partial conversion.
REQ-026 Latency from VALUE capture to display update SHALL be VAL_W+2 cycles; VALUE changes during SHIFT are ignored until the next LOAD.
REQ-027 The BCD register SHALL hold ceil(VAL_W·log10(2)) digits; a non-zero digit at or above position N_DIGITS SHALL set OVERFLOW.
REQ-028 While OVERFLOW=1, every digit SHALL show segment G only ("-").
REQ-029 The scan counter SHALL advance the active digit every SCAN_DIV cycles, in order 0..N_DIGITS-1, then wrap to 0.
REQ-030 Exactly one DIGIT bit SHALL be low at any time after reset; digit 0 is the least significant decimal digit.
REQ-031 SEG SHALL be a registered decode of the active digit (codes 0-9 only); SEG_DP SHALL be 0.

Reset
REQ-032 While FPGA_RSTB=0: KEY_LEVEL=0, KEY_PULSE=0, OVERFLOW=0, DIGIT = all-ones except bit 0 low, SEG=7'b1111110 ("0"), SEG_DP=0.
REQ-033 While FPGA_RSTB=0, all counters and BCD digits SHALL be 0 and the FSM SHALL be in IDLE; IDLE SHALL go to LOAD on the first cycle after release.
REQ-034 Reset asserted mid-debounce or mid-conversion SHALL discard the partial state; no pulse SHALL be generated on release.

Configuration
REQ-035 With VENDING_PANEL_ZBLANK_EN defined, leading-zero digits above the most significant non-zero digit SHALL be blank (SEG=0); digit 0 is never blanked.
REQ-036 Without VENDING_PANEL_ZBLANK_EN, all N_DIGITS digits SHALL display, including leading zeros.

Structure
REQ-037 The package vending_pkg SHALL hold the 7-segment decode constants (0-9, dash, blank) and the converter FSM state typedef.
REQ-038 The sub-module key_debounce SHALL implement one channel (REQ-020..022) and be instantiated N_KEYS times.

Verification (TICK_DIV=4, SCAN_DIV=8, DEBOUNCE_TICKS=3, N_DIGITS=4, VAL_W=16)
REQ-039 Hold DIP_SW[0] low for 3 ticks -> KEY_LEVEL[0]=1 and one KEY_PULSE[0] cycle; release for 3 ticks -> KEY_LEVEL[0]=0 with no pulse.
REQ-040 Toggle DIP_SW[1] low for 2 ticks, then high -> no KEY_LEVEL or KEY_PULSE change; press DIP_SW[2] and DIP_SW[3] together -> both pulses in the same cycle.
REQ-041 VALUE=1234 -> after 18 cycles, the scan shows 4,3,2,1 on DIGIT[0..3]; the sequence wraps back to DIGIT[0] after 32 cycles.
REQ-042 VALUE=10000 -> OVERFLOW=1 and all digits show "-"; VALUE=9999 -> OVERFLOW=0.
REQ-043 VALUE=7 with VENDING_PANEL_ZBLANK_EN -> digits 3..1 show SEG=0 and digit 0 shows "7"; without the macro -> "0007".
REQ-044 Assert FPGA_RSTB=0 mid-conversion and mid-debounce -> all outputs take REQ-032 values; no spurious KEY_PULSE on release.
